dram_bank_model: RTL and testbench



---
 rtl/dram_bank_model.sv | 188 ++++++++++++++++++
 tb/tb_dram_bank_model.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_model.sv
// Multi-bank DRAM timing model: per-bank row-buffer tracking, open- or closed-page policy
// and saturating hit/miss/conflict counters. One request in flight, one full row per access.
module dram_bank_model #(
   parameter int NUM_BANKS   = 4,
   parameter int NUM_ROWS    = 16,
   parameter int ROW_WIDTH   = 256,
   parameter int BURST_WIDTH = 32,
   parameter int BURST_LEN   = ROW_WIDTH / BURST_WIDTH,
   parameter int TRCD_CYCLES = 3,
   parameter int TCL_CYCLES  = 2,
   parameter int TWR_CYCLES  = 2,
   parameter int TRP_CYCLES  = 2,
   parameter bit OPEN_PAGE   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [$clog2(NUM_BANKS)-1:0] req_bank,
   input  logic [$clog2(NUM_ROWS)-1:0]  req_row,
   input  logic [BURST_WIDTH-1:0]       wdata,
   input  logic                         wdata_valid,
   output logic                         wdata_ready,
   output logic [BURST_WIDTH-1:0]       rdata,
   output logic                         rdata_valid,
   output logic                         done,
   output logic [31:0]                  hit_count,
   output logic [31:0]                  miss_count,
   output logic [31:0]                  conflict_count
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = $clog2(NUM_ROWS);
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int DEPTH  = NUM_BANKS * NUM_ROWS;
   localparam int CNT_W  = 8;

   localparam logic [CNT_W-1:0]  TRP_LAST  = CNT_W'(TRP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TRCD_LAST = CNT_W'(TRCD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TCL_LAST  = CNT_W'(TCL_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TWR_LAST  = CNT_W'(TWR_CYCLES - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

   if (BURST_LEN * BURST_WIDTH != ROW_WIDTH) begin : g_bad_geometry
      $error("ROW_WIDTH must equal BURST_LEN * BURST_WIDTH");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_PRECHARGE, S_ACTIVATE, S_CAS, S_READ_BURST,
      S_WRITE_BURST, S_TWR, S_CLOSE, S_DONE
   } state_t;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [BEAT_W-1:0]        r_beat;
   logic [BANK_W-1:0]        r_bank;
   logic [ROW_W-1:0]         r_row;
   logic                     r_write;
   logic [NUM_BANKS-1:0]     r_open;
   logic [ROW_W-1:0]         r_open_row [NUM_BANKS];
   logic [BURST_WIDTH-1:0]   r_mem [DEPTH][BURST_LEN];
   logic [BURST_WIDTH-1:0]   r_rdata;
   logic                     r_rdata_valid;
   logic [31:0]              r_hit;
   logic [31:0]              r_miss;
   logic [31:0]              r_conflict;

   logic [BANK_W+ROW_W-1:0]  w_idx;
   logic [CNT_W-1:0]         w_cnt_last;
   state_t                   w_timed_next;
   state_t                   w_after_access;

   assign w_idx          = {r_bank, r_row};
   assign w_after_access = OPEN_PAGE ? S_DONE : S_CLOSE;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
   always_comb begin
      w_cnt_last   = '0;
      w_timed_next = S_IDLE;
      case (r_state)
         S_PRECHARGE: begin w_cnt_last = TRP_LAST;  w_timed_next = S_ACTIVATE; end
         S_ACTIVATE:  begin w_cnt_last = TRCD_LAST; w_timed_next = S_CAS; end
         S_CAS:       begin
            w_cnt_last   = TCL_LAST;
            w_timed_next = r_write ? S_WRITE_BURST : S_READ_BURST;
         end
         S_TWR:       begin w_cnt_last = TWR_LAST;  w_timed_next = w_after_access; end
         S_CLOSE:     begin w_cnt_last = TRP_LAST;  w_timed_next = S_DONE; end
         default:     ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_beat        <= '0;
         r_bank        <= '0;
         r_row         <= '0;
         r_write       <= 1'b0;
         r_open        <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_hit         <= '0;
         r_miss        <= '0;
         r_conflict    <= '0;
         for (int b = 0; b < NUM_BANKS; b++) r_open_row[b] <= '0;
      end else begin
         r_rdata_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_bank  <= req_bank;
                  r_row   <= req_row;
                  r_write <= req_write;
                  if (!r_open[req_bank]) begin
                     if (r_miss != '1) r_miss <= r_miss + 32'd1;
                     r_state <= S_ACTIVATE;
                  end else if (r_open_row[req_bank] == req_row) begin
                     if (r_hit != '1) r_hit <= r_hit + 32'd1;
                     r_state <= S_CAS;
                  end else begin
                     if (r_conflict != '1) r_conflict <= r_conflict + 32'd1;
                     r_state <= S_PRECHARGE;
                  end
               end
            end
            S_PRECHARGE, S_ACTIVATE, S_CAS, S_TWR, S_CLOSE: begin
               if (r_cnt == w_cnt_last) begin
                  r_cnt   <= '0;
                  r_state <= w_timed_next;
                  if (r_state == S_ACTIVATE) begin
                     r_open[r_bank]     <= 1'b1;
                     r_open_row[r_bank] <= r_row;
                  end
                  if (r_state == S_CLOSE) r_open[r_bank] <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_READ_BURST: begin
               r_rdata       <= r_mem[w_idx][r_beat];
               r_rdata_valid <= 1'b1;
               if (r_beat == BEAT_LAST) begin
                  r_beat  <= '0;
                  r_state <= w_after_access;
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
            S_WRITE_BURST: begin
               if (wdata_valid) begin
                  if (r_beat == BEAT_LAST) begin
                     r_beat  <= '0;
                     r_state <= S_TWR;
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: memories are normally left unreset; this model must power up and reset to all-zero rows.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < BURST_LEN; j++)
               r_mem[i][j] <= '0;
      end else if (r_state == S_WRITE_BURST && wdata_valid) begin
         r_mem[w_idx][r_beat] <= wdata;
      end
   end

   assign req_ready      = (r_state == S_IDLE) && !rst;
   assign wdata_ready    = (r_state == S_WRITE_BURST);
   assign done           = (r_state == S_DONE);
   assign rdata          = r_rdata;
   assign rdata_valid    = r_rdata_valid;
   assign hit_count      = r_hit;
   assign miss_count     = r_miss;
   assign conflict_count = r_conflict;

endmodule

// File: tb/tb_dram_bank_model.sv
// Bench for dram_bank_model: an open-page and a closed-page instance share stimulus; a bank/row
// model predicts classification, latency, counters and read data (queued scoreboard).
module tb_dram_bank_model;
   localparam int TRCD = 3;
   localparam int TCL  = 2;
   localparam int TWR  = 2;
   localparam int TRP  = 2;
   localparam int BL   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_bank;
   logic [3:0]  req_row;
   logic [31:0] wdata;
   logic        wdata_valid;
   bit          sel;

   logic        op_req_valid, cp_req_valid;
   logic        op_req_ready, cp_req_ready;
   logic        op_wdata_ready, cp_wdata_ready;
   logic [31:0] op_rdata, cp_rdata;
   logic        op_rdata_valid, cp_rdata_valid;
   logic        op_done, cp_done;
   logic [31:0] op_hit, op_miss, op_conf, cp_hit, cp_miss, cp_conf;

   logic        m_req_ready, m_wdata_ready, m_rdata_valid, m_done;
   logic [31:0] m_rdata, m_hit, m_miss, m_conf;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] m_mem [2][4][16][8];
   bit          m_open [2][4];
   int          m_row [2][4];
   int          exp_cnt [2][3];
   logic [31:0] exp_q [$];
   logic [31:0] wbeats [8];

   assign op_req_valid  = req_valid && !sel;
   assign cp_req_valid  = req_valid && sel;
   assign m_req_ready   = sel ? cp_req_ready   : op_req_ready;
   assign m_wdata_ready = sel ? cp_wdata_ready : op_wdata_ready;
   assign m_rdata       = sel ? cp_rdata       : op_rdata;
   assign m_rdata_valid = sel ? cp_rdata_valid : op_rdata_valid;
   assign m_done        = sel ? cp_done        : op_done;
   assign m_hit         = sel ? cp_hit         : op_hit;
   assign m_miss        = sel ? cp_miss        : op_miss;
   assign m_conf        = sel ? cp_conf        : op_conf;

   dram_bank_model #(.TRCD_CYCLES(TRCD), .TCL_CYCLES(TCL), .TWR_CYCLES(TWR),
                     .TRP_CYCLES(TRP), .OPEN_PAGE(1'b1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(op_req_valid), .req_ready(op_req_ready),
      .req_write(req_write), .req_bank(req_bank), .req_row(req_row),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(op_wdata_ready),
      .rdata(op_rdata), .rdata_valid(op_rdata_valid), .done(op_done),
      .hit_count(op_hit), .miss_count(op_miss), .conflict_count(op_conf));

   dram_bank_model #(.TRCD_CYCLES(TRCD), .TCL_CYCLES(TCL), .TWR_CYCLES(TWR),
                     .TRP_CYCLES(TRP), .OPEN_PAGE(1'b0)) u_dut_cp (
      .clk(clk), .rst(rst), .req_valid(cp_req_valid), .req_ready(cp_req_ready),
      .req_write(req_write), .req_bank(req_bank), .req_row(req_row),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(cp_wdata_ready),
      .rdata(cp_rdata), .rdata_valid(cp_rdata_valid), .done(cp_done),
      .hit_count(cp_hit), .miss_count(cp_miss), .conflict_count(cp_conf));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Read-data scoreboard: every beat on the bus must match the head of the queue.
   always @(negedge clk) begin
      if (m_rdata_valid) begin
         check("rdata_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("rdata", m_rdata, exp_q.pop_front());
      end
   end

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 3; c++) exp_cnt[s][c] = 0;
         for (int b = 0; b < 4; b++) begin
            m_open[s][b] = 1'b0;
            m_row[s][b]  = 0;
            for (int r = 0; r < 16; r++)
               for (int i = 0; i < 8; i++) m_mem[s][b][r][i] = '0;
         end
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_hit"},      m_hit,  32'(exp_cnt[sel][0]));
      check({tag, "_miss"},     m_miss, 32'(exp_cnt[sel][1]));
      check({tag, "_conflict"}, m_conf, 32'(exp_cnt[sel][2]));
   endtask

   // Called at posedge+1; returns at posedge+1 after the acceptance edge.
   task automatic issue(input bit wr, input int bank, input int row, output int k, output int base);
      int cls;
      if (!m_open[sel][bank]) begin
         cls = 1; base = TRCD;
      end else if (m_row[sel][bank] == row) begin
         cls = 0; base = 0;
      end else begin
         cls = 2; base = TRP + TRCD;
      end
      exp_cnt[sel][cls]++;
      m_open[sel][bank] = !sel;
      m_row[sel][bank]  = row;
      for (int i = 0; i < BL; i++) begin
         if (wr) m_mem[sel][bank][row][i] = wbeats[i];
         else    exp_q.push_back(m_mem[sel][bank][row][i]);
      end
      req_valid = 1'b1;
      req_write = wr;
      req_bank  = 2'(bank);
      req_row   = 4'(row);
      @(negedge clk);
      check("accept_ready", 32'(m_req_ready), 32'd1);
      k = cyc;
      @(posedge clk); #1;
      // Scramble request fields: the DUT must use what it latched.
      req_valid = 1'b0;
      req_write = !wr;
      req_bank  = ~req_bank;
      req_row   = ~req_row;
   endtask

   task automatic access(input string tag, input bit wr, input int bank, input int row,
                         input int stall_at, input int stall_len);
      int k, base, first, burst, done_at, idx, stalls, exp_first, exp_burst, exp_done;
      bit act;
      issue(wr, bank, row, k, base);
      first = -1; burst = 0; done_at = -1; idx = 0; stalls = 0;
      for (int c = 0; c < 300 && done_at < 0; c++) begin
         if (wr) begin
            if (idx == stall_at && stalls < stall_len) wdata_valid = 1'b0;
            else if (idx < BL) begin
               wdata_valid = 1'b1;
               wdata       = wbeats[idx];
            end else wdata_valid = 1'b0;
         end
         @(negedge clk);
         act = wr ? m_wdata_ready : m_rdata_valid;
         if (act) begin
            if (first < 0) first = cyc - k - 1;
            burst++;
         end
         if (wr && m_wdata_ready) begin
            if (wdata_valid) idx++;
            else stalls++;
         end
         if (m_done && done_at < 0) done_at = cyc - k - 1;
         @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
      exp_first = wr ? base + TCL : base + TCL + 1;
      exp_burst = BL + (wr ? stall_len : 0);
      exp_done  = wr ? exp_first + exp_burst + TWR : exp_first + BL - 1;
      if (sel) exp_done += TRP;
      check({tag, "_first_latency"}, 32'(first),   32'(exp_first));
      check({tag, "_burst_cycles"},  32'(burst),   32'(exp_burst));
      check({tag, "_done_latency"},  32'(done_at), 32'(exp_done));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(m_done),      32'd0);
      check({tag, "_ready_again"},    32'(m_req_ready), 32'd1);
      check({tag, "_queue_drained"},  32'(exp_q.size()), 32'd0);
      check_counters(tag);
      @(posedge clk); #1;
   endtask

   initial begin
      int k, base, cnt;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bank = '0; req_row = '0;
      wdata = '0; wdata_valid = 1'b0; sel = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready_low", 32'(m_req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_ready",       32'(m_req_ready),   32'd1);
      check("post_reset_ready_cp",    32'(cp_req_ready),  32'd1);
      check("post_reset_rdata_valid", 32'(m_rdata_valid), 32'd0);
      check("post_reset_wdata_ready", 32'(m_wdata_ready), 32'd0);
      check("post_reset_done",        32'(m_done),        32'd0);
      check("post_reset_rdata",       m_rdata,            32'd0);
      check_counters("post_reset");
      @(posedge clk); #1;

      for (int i = 0; i < BL; i++) wbeats[i] = 32'h1111_1111 * 32'(i + 1);
      access("wr_b1r5_miss",  1'b1, 1, 5, -1, 0);
      access("rd_b1r5_hit",   1'b0, 1, 5, -1, 0);
      access("rd_b1r6_conf",  1'b0, 1, 6, -1, 0);
      access("rd_b2r5_miss",  1'b0, 2, 5, -1, 0);
      for (int i = 0; i < BL; i++) wbeats[i] = $urandom();
      access("wr_b3r9_stall", 1'b1, 3, 9, 3, 2);
      access("rd_b3r9_hit",   1'b0, 3, 9, -1, 0);
      for (int i = 0; i < BL; i++) wbeats[i] = $urandom();
      access("wr_b1r6_hit",   1'b1, 1, 6, -1, 0);
      access("rd_b1r5_conf",  1'b0, 1, 5, -1, 0);
      access("rd_b2r5_hit",   1'b0, 2, 5, -1, 0);

      sel = 1'b1;
      access("cp_rd_b0r0_a",  1'b0, 0, 0, -1, 0);
      access("cp_rd_b0r0_b",  1'b0, 0, 0, -1, 0);
      for (int i = 0; i < BL; i++) wbeats[i] = $urandom();
      access("cp_wr_b0r0",    1'b1, 0, 0, -1, 0);
      access("cp_rd_b0r0_c",  1'b0, 0, 0, -1, 0);
      sel = 1'b0;

      // Reset while beat 4 of a read is on the bus.
      issue(1'b0, 1, 5, k, base);
      cnt = 0;
      for (int c = 0; c < 100 && cnt < 4; c++) begin
         @(negedge clk);
         if (m_rdata_valid) cnt++;
      end
      check("rst_mid_beats_seen", 32'(cnt), 32'd4);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_beat4_valid", 32'(m_rdata_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_mid_rdata_valid", 32'(m_rdata_valid), 32'd0);
      check("rst_mid_done",        32'(m_done),        32'd0);
      check("rst_mid_wdata_ready", 32'(m_wdata_ready), 32'd0);
      check("rst_mid_ready",       32'(m_req_ready),   32'd0);
      check("rst_mid_rdata",       m_rdata,            32'd0);
      exp_q.delete();
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_rel_ready", 32'(m_req_ready), 32'd1);
      check_counters("rst_rel");
      check("rst_rel_cp_hit",  cp_hit,  32'd0);
      check("rst_rel_cp_miss", cp_miss, 32'd0);
      check("rst_rel_cp_conf", cp_conf, 32'd0);
      @(posedge clk); #1;
      access("rd_b1r5_after_rst", 1'b0, 1, 5, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
